// File: rtl/c432_key_cfg_ctrl.sv
// Serial key loader for the MUX2-obfuscated c432 core.
// Parity-checked shadow key; only a validated key reaches key_out.
module c432_key_cfg_ctrl #(
  parameter int KEY_W     = 2,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             bit_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err,
  output logic             lockout
);

  localparam int CW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT, PAR, CHECK, LOCKED, FAIL, DEAD
  } state_t;

  state_t           state, state_nxt;
  logic [KEY_W-1:0] shadow, shadow_nxt;
  logic [KEY_W-1:0] key_nxt;
  logic             par_rx, par_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [RW-1:0]    retry, retry_nxt;
  logic [RW-1:0]    retry_inc;
  logic             valid_nxt, err_nxt;
  logic             accept, tmo, do_fail;

  assign bit_ready = (state == SHIFT) || (state == PAR);
  assign busy      = bit_ready || (state == CHECK);
  assign lockout   = (state == DEAD);
  assign accept    = bit_valid & bit_ready;
  // an accepted bit always beats an expiring timer
  assign tmo       = (timer == TW'(TIMEOUT - 1)) & ~accept;
  assign retry_inc = retry + 1'b1;

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    par_nxt    = par_rx;
    cnt_nxt    = cnt;
    timer_nxt  = timer;
    retry_nxt  = retry;
    key_nxt    = key_out;
    valid_nxt  = key_valid;
    err_nxt    = err;
    do_fail    = 1'b0;
    unique case (state)
      IDLE, LOCKED, FAIL: begin
        if (load_start) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          timer_nxt = '0;
          err_nxt   = 1'b0;
        end
      end
      SHIFT: begin
        if (accept) begin
          shadow_nxt[cnt] = bit_data;
          cnt_nxt         = cnt + 1'b1;
          timer_nxt       = '0;
          if (cnt == CW'(KEY_W - 1))
            state_nxt = PAR;
        end else if (tmo) begin
          do_fail = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      PAR: begin
        if (accept) begin
          par_nxt   = bit_data;
          timer_nxt = '0;
          state_nxt = CHECK;
        end else if (tmo) begin
          do_fail = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      CHECK: begin
        if ((^shadow ^ par_rx) == 1'b0) begin
          key_nxt   = shadow;
          valid_nxt = 1'b1;
          retry_nxt = '0;
          state_nxt = LOCKED;
        end else begin
          do_fail = 1'b1;
        end
      end
      DEAD: ;
      default: state_nxt = IDLE;
    endcase
    if (do_fail) begin
      key_nxt   = '0;
      valid_nxt = 1'b0;
      err_nxt   = 1'b1;
      retry_nxt = retry_inc;
      state_nxt = (retry_inc == RW'(MAX_RETRY)) ? DEAD : FAIL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      par_rx    <= 1'b0;
      cnt       <= '0;
      timer     <= '0;
      retry     <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      par_rx    <= par_nxt;
      cnt       <= cnt_nxt;
      timer     <= timer_nxt;
      retry     <= retry_nxt;
      key_out   <= key_nxt;
      key_valid <= valid_nxt;
      err       <= err_nxt;
    end
  end

endmodule
